// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller driving the PC register.
// Moore FSM with interrupt entry, halt/resume and a fetch watchdog.
module pc_sequencer #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int TIMEOUT_WIDTH = 5,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk_seq,
  input  logic                   reset_seq,
  input  logic                   mem_ready,
  input  logic                   exec_done,
  input  logic                   branch_taken,
  input  logic                   iret,
  input  logic                   halt,
  input  logic                   irq,
  input  logic                   irq_en,
  input  logic                   run,
  output logic [1:0]             PC_IS,
  output logic                   PC_regload,
  output logic                   PC_regen,
  output logic                   AD_sel,
  output logic                   mem_rd,
  output logic                   ir_load,
  output logic                   exec_start,
  output logic                   irq_ack,
  output logic                   in_isr,
  output logic                   err,
  output logic [2:0]             state_out,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [2:0] {
    S_RST    = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_UPDATE = 3'b100,
    S_IRQ    = 3'b101,
    S_HALT   = 3'b110,
    S_ERR    = 3'b111
  } state_t;

  state_t                   state, state_nx;
  logic [TIMEOUT_WIDTH-1:0] wd;
  logic [COUNT_WIDTH-1:0]   cnt;
  logic                     isr, isr_nx;
  logic                     br_l, iret_l, halt_l;
  logic                     first;
  logic                     wd_last, irq_ok;

  assign wd_last = wd == TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

  // iret clears in_isr on the same edge the irq decision is made
  always_comb begin
    isr_nx = isr;
    if (state == S_UPDATE && iret_l)
      isr_nx = 1'b0;
    else if (state == S_IRQ)
      isr_nx = 1'b1;
  end

  assign irq_ok = irq & irq_en & ~isr_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:    state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_nx = S_DECODE;
        else if (wd_last) state_nx = S_ERR;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   if (exec_done) state_nx = S_UPDATE;
      S_UPDATE: begin
        if (halt_l)      state_nx = S_HALT;
        else if (irq_ok) state_nx = S_IRQ;
        else             state_nx = S_FETCH;
      end
      S_IRQ:    state_nx = S_FETCH;
      S_HALT: begin
        if (run)         state_nx = S_FETCH;
        else if (irq_ok) state_nx = S_IRQ;
      end
      S_ERR:    state_nx = S_ERR;
    endcase
  end

  always_ff @(posedge clk_seq or negedge reset_seq) begin
    if (!reset_seq) begin
      state  <= S_RST;
      wd     <= '0;
      cnt    <= '0;
      isr    <= 1'b0;
      br_l   <= 1'b0;
      iret_l <= 1'b0;
      halt_l <= 1'b0;
      first  <= 1'b0;
    end else begin
      state <= state_nx;
      isr   <= isr_nx;
      first <= state == S_DECODE;
      if (state == S_FETCH && !mem_ready)
        wd <= wd + TIMEOUT_WIDTH'(1);
      else
        wd <= '0;
      if (state == S_FETCH && mem_ready)
        cnt <= cnt + COUNT_WIDTH'(1);
      if (state == S_EXEC && exec_done) begin
        br_l   <= branch_taken | iret;
        iret_l <= iret;
        halt_l <= halt;
      end else if (state == S_UPDATE) begin
        br_l   <= 1'b0;
        iret_l <= 1'b0;
        halt_l <= 1'b0;
      end
    end
  end

  // reset-vector load strobe is suppressed while reset is still held
  always_comb begin
    PC_IS      = 2'b00;
    PC_regload = 1'b0;
    PC_regen   = 1'b0;
    AD_sel     = 1'b0;
    mem_rd     = 1'b0;
    ir_load    = 1'b0;
    exec_start = 1'b0;
    irq_ack    = 1'b0;
    err        = 1'b0;
    unique case (state)
      S_RST: begin
        PC_IS      = 2'b10;
        PC_regload = reset_seq;
        PC_regen   = 1'b1;
      end
      S_FETCH: begin
        PC_IS    = 2'b11;
        AD_sel   = 1'b1;
        mem_rd   = 1'b1;
        PC_regen = 1'b1;
      end
      S_DECODE: begin
        ir_load  = 1'b1;
        PC_regen = 1'b1;
      end
      S_EXEC:   exec_start = first;
      S_UPDATE: begin
        PC_IS      = br_l ? 2'b00 : 2'b11;
        PC_regload = 1'b1;
        PC_regen   = 1'b1;
      end
      S_IRQ: begin
        PC_IS      = 2'b01;
        PC_regload = 1'b1;
        PC_regen   = 1'b1;
        irq_ack    = 1'b1;
      end
      S_HALT:   ;
      S_ERR:    err = 1'b1;
    endcase
  end

  assign in_isr      = isr;
  assign state_out   = state;
  assign fetch_count = cnt;

endmodule
